// File: rtl/rotary_decoder.sv
// Purpose: synchronise, debounce and quadrature-decode a rotary encoder into one-cycle detent pulses.
// Latency: pin change first captured at edge N -> rotate_out/position_out registered at edge N+DEBOUNCE_CYCLES+2.
// Backpressure: none; rotate_out is a fire-and-forget 1-cycle pulse, position_out is a free-running count.
//
// Ports:
//   clk          - system clock
//   rst          - synchronous active-high reset
//   enc_a_in     - raw encoder channel A (asynchronous, bouncy)
//   enc_b_in     - raw encoder channel B (asynchronous, bouncy)
//   rotate_out   - 2'b01 one CW detent, 2'b10 one CCW detent, 2'b00 idle (1-cycle pulse)
//   position_out - wrapping detent count, +1 per CW, -1 per CCW
module rotary_decoder #(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enc_a_in,
    input  logic                 enc_b_in,
    output logic [1:0]           rotate_out,
    output logic [POS_WIDTH-1:0] position_out
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Wide enough to hold +/-STEPS_PER_DETENT as a signed value.
    localparam int STEP_W = $clog2(STEPS_PER_DETENT + 1) + 1;
    localparam logic signed [STEP_W-1:0] STEP_MAX = STEP_W'(STEPS_PER_DETENT);
    localparam logic signed [STEP_W-1:0] STEP_MIN = -STEP_MAX;

    // Channel vectors are ordered {A, B}: bit 1 = A, bit 0 = B.
    logic [1:0] raw_ab;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] db_q, db_d;
    logic [1:0] prev_q;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];

    logic signed [STEP_W-1:0] step_q, step_d, step_nxt;
    logic [1:0]               rot_q, rot_d;
    logic [POS_WIDTH-1:0]     pos_q, pos_d;
    logic [1:0]               phase_diff;

    assign raw_ab = {enc_a_in, enc_b_in};

    // Position of a {A,B} state along the CW cycle 00->10->11->01.
    function automatic logic [1:0] cw_index(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            2'b00:   idx = 2'd0;
            2'b10:   idx = 2'd1;
            2'b11:   idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Modulo-4 phase difference: 1 = CW step, 3 = CCW step, 2 = both bits
    // flipped (invalid, includes simultaneous A/B updates), 0 = no change.
    assign phase_diff = cw_index(db_q) - cw_index(prev_q);

    always_comb begin
        step_d   = step_q;
        rot_d    = 2'b00;
        pos_d    = pos_q;
        step_nxt = step_q;
        case (phase_diff)
            2'd1: begin
                step_nxt = step_q + STEP_W'(1);
                if (step_nxt == STEP_MAX) begin
                    rot_d  = 2'b01;
                    pos_d  = pos_q + 1'b1;
                    step_d = '0;
                end else begin
                    step_d = step_nxt;
                end
            end
            2'd3: begin
                step_nxt = step_q - STEP_W'(1);
                if (step_nxt == STEP_MIN) begin
                    rot_d  = 2'b10;
                    pos_d  = pos_q - 1'b1;
                    step_d = '0;
                end else begin
                    step_d = step_nxt;
                end
            end
            2'd2: begin
                step_d = '0;
            end
            default: begin
            end
        endcase
    end

    // Reset loads the live pin levels through the whole pipeline so that
    // releasing reset never looks like a transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= raw_ab;
            sync2_q <= raw_ab;
            db_q    <= raw_ab;
            prev_q  <= raw_ab;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            step_q  <= '0;
            rot_q   <= 2'b00;
            pos_q   <= '0;
        end else begin
            sync1_q <= raw_ab;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            prev_q  <= db_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            step_q  <= step_d;
            rot_q   <= rot_d;
            pos_q   <= pos_d;
        end
    end

    assign rotate_out   = rot_q;
    assign position_out = pos_q;

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder with DEBOUNCE_CYCLES=4, STEPS_PER_DETENT=4, POS_WIDTH=8.
// Pins change 20 cycles apart; outputs are sampled 1 time unit after each rising edge.
module tb_rotary_decoder;

    logic       clk;
    logic       rst;
    logic       enc_a_in;
    logic       enc_b_in;
    logic [1:0] rotate_out;
    logic [7:0] position_out;

    int total = 0;
    int bad   = 0;
    int cw_cnt   = 0;
    int ccw_cnt  = 0;
    int code3_cnt = 0;

    rotary_decoder #(
        .DEBOUNCE_CYCLES (4),
        .STEPS_PER_DETENT(4),
        .POS_WIDTH       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enc_a_in    (enc_a_in),
        .enc_b_in    (enc_b_in),
        .rotate_out  (rotate_out),
        .position_out(position_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and tally any pulse seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rotate_out == 2'b01) cw_cnt++;
        if (rotate_out == 2'b10) ccw_cnt++;
        if (rotate_out == 2'b11) code3_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_ab(input logic a, input logic b);
        enc_a_in = a;
        enc_b_in = b;
        ticks(20);
    endtask

    task automatic do_reset(input logic a, input logic b, input int n);
        rst      = 1'b1;
        enc_a_in = a;
        enc_b_in = b;
        ticks(n);
        rst      = 1'b0;
        cw_cnt   = 0;
        ccw_cnt  = 0;
    endtask

    // Glitch A for 3 cycles, restore it briefly, then settle on the target.
    task automatic glitch_step(input logic a, input logic b);
        logic a_cur;
        a_cur    = enc_a_in;
        enc_a_in = ~a_cur;
        ticks(3);
        enc_a_in = a_cur;
        ticks(2);
        set_ab(a, b);
    endtask

    task automatic cw_detent();
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
        set_ab(1'b0, 1'b1);
        set_ab(1'b0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        enc_a_in = 1'b0;
        enc_b_in = 1'b0;

        // 1. reset state and quiet period
        do_reset(1'b0, 1'b0, 3);
        check("reset_rotate", 32'(rotate_out), 32'h0);
        check("reset_pos", 32'(position_out), 32'h0);
        ticks(50);
        check("idle_no_pulse", 32'(cw_cnt + ccw_cnt), 32'd0);

        // 2. one CW detent with exact pulse timing on the final change
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
        set_ab(1'b0, 1'b1);
        check("cw_no_early_pulse", 32'(cw_cnt), 32'd0);
        enc_a_in = 1'b0;
        enc_b_in = 1'b0;
        ticks(6);
        check("cw_before_pulse", 32'(rotate_out), 32'h0);
        tick();
        check("cw_pulse", 32'(rotate_out), 32'h1);
        check("cw_pos_at_pulse", 32'(position_out), 32'h1);
        tick();
        check("cw_pulse_width", 32'(rotate_out), 32'h0);
        ticks(12);
        check("cw_pulse_count", 32'(cw_cnt), 32'd1);
        check("cw_pos", 32'(position_out), 32'h01);

        // 3. one CCW detent from reset
        do_reset(1'b0, 1'b0, 3);
        check("ccw_reset_pos", 32'(position_out), 32'h0);
        set_ab(1'b0, 1'b1);
        set_ab(1'b1, 1'b1);
        set_ab(1'b1, 1'b0);
        set_ab(1'b0, 1'b0);
        check("ccw_pulse_count", 32'(ccw_cnt), 32'd1);
        check("ccw_no_cw", 32'(cw_cnt), 32'd0);
        check("ccw_pos", 32'(position_out), 32'hFF);

        // 4. CW detent with 3-cycle glitches on A before each transition
        do_reset(1'b0, 1'b0, 3);
        glitch_step(1'b1, 1'b0);
        glitch_step(1'b1, 1'b1);
        glitch_step(1'b0, 1'b1);
        glitch_step(1'b0, 1'b0);
        check("glitch_cw_count", 32'(cw_cnt), 32'd1);
        check("glitch_ccw_count", 32'(ccw_cnt), 32'd0);
        check("glitch_pos", 32'(position_out), 32'h01);

        // 5. invalid step then 3 CW steps: no pulse
        do_reset(1'b0, 1'b0, 3);
        set_ab(1'b1, 1'b1);
        set_ab(1'b0, 1'b1);
        set_ab(1'b0, 1'b0);
        set_ab(1'b1, 1'b0);
        check("invalid_no_pulse", 32'(cw_cnt + ccw_cnt), 32'd0);
        check("invalid_pos", 32'(position_out), 32'h0);

        // 5b. partial progress is discarded by an invalid step
        do_reset(1'b0, 1'b0, 3);
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
        set_ab(1'b0, 1'b0);
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
        set_ab(1'b0, 1'b1);
        check("invalid_clears_progress", 32'(cw_cnt), 32'd0);
        set_ab(1'b0, 1'b0);
        check("after_invalid_fourth_step", 32'(cw_cnt), 32'd1);

        // 6. reset mid-detent discards partial progress
        do_reset(1'b0, 1'b0, 3);
        set_ab(1'b1, 1'b0);
        set_ab(1'b1, 1'b1);
        set_ab(1'b0, 1'b1);
        do_reset(1'b0, 1'b1, 1);
        set_ab(1'b0, 1'b0);
        check("midreset_no_pulse", 32'(cw_cnt + ccw_cnt), 32'd0);
        check("midreset_pos", 32'(position_out), 32'h0);

        // 7. position wrap after 256 CW detents
        do_reset(1'b0, 1'b0, 3);
        for (int d = 0; d < 255; d++) cw_detent();
        check("wrap_count_255", 32'(cw_cnt), 32'd255);
        check("wrap_pos_ff", 32'(position_out), 32'hFF);
        cw_detent();
        check("wrap_pos_00", 32'(position_out), 32'h00);

        check("never_code_11", 32'(code3_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
